// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin share of the register-file write port between ALU (A) and load (B) writeback,
// with a registered write strobe and a busy-register scoreboard for read-hazard detection.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData
);
    localparam int NREG = 2 ** ADDR_W;

    logic              last_b_q, last_b_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              xfer;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_data;

    // last_b_q=1 means B was granted last, so A has priority on contention
    always_comb begin
        a_ready = !rst && !hold && a_valid && (!b_valid || last_b_q);
        b_ready = !rst && !hold && b_valid && (!a_valid || !last_b_q);
        xfer    = a_ready || b_ready;
        x_addr  = a_ready ? a_addr : b_addr;
        x_data  = a_ready ? a_data : b_data;
    end

    always_comb begin
        last_b_d     = xfer ? b_ready : last_b_q;
        reg_write_d  = xfer && (x_addr != '0);
        write_reg_d  = reg_write_d ? x_addr : write_reg_q;
        write_data_d = reg_write_d ? x_data : write_data_q;
        busy_d       = busy_q;
        if (reg_write_d)
            busy_d[x_addr] = 1'b0;
        // a reservation issued on the same edge as the writeback belongs to a newer producer
        if (res_valid)
            busy_d[res_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q     <= 1'b1;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            last_b_q     <= last_b_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign hazard1   = busy_q[RR1];
    assign hazard2   = busy_q[RR2];
    assign RegWrite  = reg_write_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (RegWrite / WriteReg / WriteData) between two writeback requesters: A = ALU writeback, B = load/memory writeback.
- Arbitration is round-robin with a valid/ready handshake and a registered write strobe toward the register file.
- Holds a busy-register scoreboard (reserve at issue, clear at writeback) and reports read hazards for the two read addresses RR1/RR2.

Parameters:
DATA_W, 32, write-data width
ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
hold  input  1  stall; while high no request is granted
a_valid  input  1  requester A has a write
a_ready  output  1  A granted this cycle (combinational)
a_addr  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
b_valid  input  1  requester B has a write
b_ready  output  1  B granted this cycle (combinational)
b_addr  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
res_valid  input  1  reserve a destination at issue
res_addr  input  ADDR_W  register to mark busy
RR1  input  ADDR_W  read address 1 (hazard check)
RR2  input  ADDR_W  read address 2 (hazard check)
hazard1  output  1  RR1 is busy (combinational)
hazard2  output  1  RR2 is busy (combinational)
RegWrite  output  1  register-file write strobe (registered)
WriteReg  output  ADDR_W  register-file write address (registered)
WriteData  output  DATA_W  register-file write data (registered)

Behaviour:
- Reset (async, rst=1):
  - RegWrite=0, WriteReg=0, WriteData=0.
  - All busy bits cleared.
  - last_grant=B, so A wins the first contention.
  - A transfer at the reset edge is discarded.
  - While rst=1, a_ready=b_ready=0.
- Grant (combinational, same cycle):
  - hold=1 → no grant.
  - Only one requester valid → that requester is granted.
  - Both valid → the requester not in last_grant is granted.
  - At most one ready is high per cycle.
  - ready never depends on the requester's own ready.
- Transfer: valid&ready at a rising edge. last_grant updates only on a transfer.
- Write latency 1: the cycle after a transfer, RegWrite=1 with WriteReg/WriteData = transferred addr/data. With no transfer, RegWrite=0 and WriteReg/WriteData hold their last value.
- Address 0:
  - The transfer completes normally (ready asserted, last_grant updated).
  - RegWrite stays 0; busy is not touched.
- Back-to-back: consecutive transfers produce RegWrite high on consecutive cycles. No bubble is inserted.
- Scoreboard (one busy bit per register, bit 0 always 0):
  - Set at the edge where res_valid=1 and res_addr≠0.
  - Cleared at the edge where a nonzero-address transfer occurs for that address.
  - Set and clear of the same address in the same edge: set wins (new reservation).
  - Reserving an already-busy register: stays busy (no counting).
- hazard1 = busy[RR1], hazard2 = busy[RR2], combinational. Both are 0 when the address is 0.
- Busy clears at the transfer edge, coincident with RegWrite rising. A consumer seeing hazard=0 reads the register file one cycle later.
- hold rising while a requester waits: its request stays pending and keeps its round-robin turn. last_grant is unchanged.

Test Plan:
- Reset then single A write (a_valid=1, a_addr=5, a_data=0xDEADBEEF, one cycle) → a_ready=1 same cycle; next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; following cycle RegWrite=0.
- Both valid for 4 cycles (A: reg 3, data 0x11; B: reg 4, data 0x22) → grants A,B,A,B; RegWrite stays high 4 consecutive cycles with WriteReg 3,4,3,4.
- Write to reg 0 (b_valid=1, b_addr=0, data 0xFFFF) → b_ready=1, RegWrite stays 0; next contention grants A.
- res_valid=1, res_addr=7; then RR1=7 → hazard1=1. Then A writes reg 7 → hazard1=0 in the cycle after the transfer edge. RR2=0 → hazard2=0 throughout.
- Same edge: reserve reg 9 and transfer to reg 9 → RegWrite=1, WriteReg=9, and busy[9] remains 1 (hazard with RR1=9).
- hold=1 with both valid for 3 cycles → a_ready=b_ready=0, RegWrite=0. Assert rst mid-stream while both are valid → RegWrite=0 immediately, all hazards 0, first grant after reset goes to A.
